fixed_point_divider: RTL

//   Sequential signed fixed-point divider: result = (operand_1 << FBITS) / operand_2.

---
 rtl/fixed_point_divider.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: result = (operand_1 << FBITS) / operand_2.
// Radix-2 restoring, one quotient bit per clock; truncates toward zero and saturates.
module fixed_point_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned N  = WIDTH + FBITS;
  localparam int unsigned CW = $clog2(N);

  localparam logic [N-1:0]     POS_LIM = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0]     NEG_LIM = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             zero_div_q, zero_div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_neg;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mag_b_q    <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      zero_div_q <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mag_b_q    <= mag_b_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      zero_div_q <= zero_div_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    mag_b_d    = mag_b_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    zero_div_d = zero_div_q;
    result_d   = result_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;

    // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    mag_a  = a_q[WIDTH-1] ? (-a_q) : a_q;
    mag_b  = b_q[WIDTH-1] ? (-b_q) : b_q;
    rem_sh = {rem_q, dvd_q[N-1]};
    diff   = rem_sh - {1'b0, mag_b_q};
    q_neg  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) && (dvd_q != '0);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          a_d     = operand_1;
          b_d     = operand_2;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        mag_b_d    = mag_b;
        zero_div_d = (b_q == '0);
        if (b_q == '0) begin
          state_d = S_FIX;
        end else begin
          dvd_d   = {mag_a, FBITS'(0)};
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        // Quotient bits shift in behind the dividend bits as they are consumed.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_DONE;
        if (zero_div_q) begin
          result_d = a_q[WIDTH-1] ? MIN_NEG : MAX_POS;
          dbz_d    = 1'b1;
          ovf_d    = 1'b0;
        end else if (!q_neg) begin
          if (dvd_q > POS_LIM) begin
            result_d = MAX_POS;
            ovf_d    = 1'b1;
          end else begin
            result_d = dvd_q[WIDTH-1:0];
          end
        end else begin
          if (dvd_q > NEG_LIM) begin
            result_d = MIN_NEG;
            ovf_d    = 1'b1;
          end else begin
            result_d = -dvd_q[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result      = result_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule
